// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key scheduler: key-length encodings, mode lookups,
// Rcon and S-box tables, and the one-hot scheduler state encoding.
package aes_key_pkg;

  localparam logic [1:0] KEY_128  = 2'd0;
  localparam logic [1:0] KEY_192  = 2'd1;
  localparam logic [1:0] KEY_256  = 2'd2;
  localparam logic [1:0] KEY_RSVD = 2'd3;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    SUBW = 4'b0010,
    WORD = 4'b0100,
    OUT  = 4'b1000
  } state_t;

  // Entry 0 is only ever read for the first Nk words, where it is masked out anyway.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] len);
    case (len)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [2:0] word_mod(input logic [5:0] n, input logic [1:0] len);
    case (len)
      KEY_128: return {1'b0, n[1:0]};
      KEY_192: return 3'(n % 6'd6);
      default: return n[2:0];
    endcase
  endfunction

  function automatic logic [3:0] rcon_idx(input logic [5:0] n, input logic [1:0] len);
    case (len)
      KEY_128: return 4'(n >> 2);
      KEY_192: return 4'(n / 6'd6);
      default: return 4'(n >> 3);
    endcase
  endfunction

  // True when word n takes the S-box path (RotWord/SubWord or the 256-bit mid-key SubWord).
  function automatic logic needs_sub(input logic [5:0] n, input logic [1:0] len);
    logic [2:0] m;
    m = word_mod(n, len);
    return (n >= 6'(nk_of(len))) && ((m == 3'd0) || ((len == KEY_256) && (m == 3'd4)));
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four registered byte S-boxes sharing one enable, result valid one cycle later.
module aes_subword
  import aes_key_pkg::*;
(
  input  logic        mclk,
  input  logic        arst_n,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    logic [7:0] q;

    always_ff @(posedge mclk or negedge arst_n) begin
      if (!arst_n) q <= '0;
      else if (en) q <= SBOX[din[8*b +: 8]];
    end

    assign dout[8*b +: 8] = q;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Unified AES-128/192/256 key schedule: one schedule word per cycle, packed into
// 128-bit round keys offered on a valid/ready interface.
module aes_key_expander
  import aes_key_pkg::*;
#(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         mclk,
  input  logic         arst_n,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  input  logic         start,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t      state;
  logic [255:0] key_q;
  logic [1:0]  len_q;
  logic [5:0]  i;
  logic [31:0] win [8];
  logic [95:0] acc;
  logic [31:0] kw [8];
  logic [31:0] sub_in, sub_out, temp, w_new;
  logic [3:0]  nk, nr;
  logic [2:0]  i_mod;
  logic        len_ok;

  assign nk    = nk_of(len_q);
  assign nr    = nr_of(len_q);
  assign i_mod = word_mod(i, len_q);
  assign busy  = (state != IDLE);

  always_comb begin
    for (int k = 0; k < 8; k++) kw[k] = key_q[255 - 32*k -: 32];
  end

  always_comb begin
    case (key_len)
      KEY_128: len_ok = 1'b1;
      KEY_192: len_ok = SUPPORT_192;
      KEY_256: len_ok = SUPPORT_256;
      default: len_ok = 1'b0;
    endcase
  end

  // win[0] is w[i-1], so w[i-Nk] sits at win[Nk-1].
  assign sub_in = (i_mod == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];

  always_comb begin
    temp = win[0];
    if (i_mod == 3'd0) temp = sub_out ^ {RCON[rcon_idx(i, len_q)], 24'h0};
    else if ((len_q == KEY_256) && (i_mod == 3'd4)) temp = sub_out;
    w_new = (i < 6'(nk)) ? kw[i[2:0]] : (win[3'(nk - 4'd1)] ^ temp);
  end

  aes_subword u_subword (
    .mclk   (mclk),
    .arst_n (arst_n),
    .en     (state == SUBW),
    .din    (sub_in),
    .dout   (sub_out)
  );

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      key_q    <= '0;
      len_q    <= KEY_128;
      i        <= '0;
      acc      <= '0;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              key_q <= key_in;
              len_q <= key_len;
              i     <= '0;
              state <= WORD;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SUBW: state <= WORD;
        WORD: begin
          win[0] <= w_new;
          for (int k = 1; k < 8; k++) win[k] <= win[k-1];
          acc <= {acc[63:0], w_new};
          i   <= i + 6'd1;
          if (i[1:0] == 2'd3) begin
            rk       <= {acc, w_new};
            rk_idx   <= i[5:2];
            rk_valid <= 1'b1;
            state    <= OUT;
          end else if (needs_sub(i + 6'd1, len_q)) begin
            state <= SUBW;
          end else begin
            state <= WORD;
          end
        end
        OUT: begin
          if (rk_ready) begin
            rk_valid <= 1'b0;
            if (rk_idx == nr) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (needs_sub(i, len_q)) begin
              state <= SUBW;
            end else begin
              state <= WORD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander against a FIPS-197 KeyExpansion model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_key_expander;

  logic         mclk = 1'b0;
  logic         arst_n = 1'b0;
  logic [255:0] key_in = '0;
  logic [1:0]   key_len = '0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done, err;

  logic         start2 = 1'b0;
  logic [1:0]   key_len2 = '0;
  logic [127:0] rk2;
  logic [3:0]   rk_idx2;
  logic         rk_valid2, busy2, done2, err2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_m [256];
  logic [31:0]  exp_w [60];
  logic [127:0] cap [15];

  always #5 mclk = ~mclk;

  aes_key_expander dut (
    .mclk(mclk), .arst_n(arst_n), .key_in(key_in), .key_len(key_len), .start(start),
    .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done), .err(err)
  );

  aes_key_expander #(.SUPPORT_192(1'b0), .SUPPORT_256(1'b1)) dut_n192 (
    .mclk(mclk), .arst_n(arst_n), .key_in(key_in), .key_len(key_len2), .start(start2),
    .rk(rk2), .rk_idx(rk_idx2), .rk_valid(rk_valid2), .rk_ready(rk_ready),
    .busy(busy2), .done(done2), .err(err2)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  task automatic ref_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        exp_w[i] = key[255 - 32*i -: 32];
      end else begin
        t = exp_w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]});
          rc = 8'h01;
          for (int k = 1; k < i / nk; k++) rc = xtime(rc);
          t ^= {rc, 24'h0};
        end else if (nk == 8 && i % 8 == 4) begin
          t = subw(t);
        end
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rk"}, rk, 0);
    check({tag, "_rk_idx"}, rk_idx, 0);
    check({tag, "_rk_valid"}, rk_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // mode 0: rk_ready held high; mode 1: random ready, 5-cycle stall at beat 3, random start/key noise.
  task automatic applyStimulus(input logic [255:0] key, input logic [1:0] len, input int mode,
                               input int abort_beat);
    int nk, nr, budget, beat, edge_n, hs_edge, stalls, stall3;
    logic was_stall, rdy;
    logic [127:0] held_rk;
    logic [3:0] held_idx;
    nk = 4 + 2 * int'(len);
    nr = nk + 6;
    budget = (len == 2'd0) ? 65 : (len == 2'd1) ? 73 : 88;
    ref_expand(key, nk);
    @(negedge mclk);
    key_in = key; key_len = len; start = 1'b1; rk_ready = 1'b1;
    @(negedge mclk);
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    key_len = 2'($urandom);
    edge_n = 1; beat = 0; hs_edge = 0; stalls = 0; stall3 = 0; was_stall = 1'b0;
    held_rk = '0; held_idx = '0;
    while (beat <= nr && edge_n < 400) begin
      check("busy_during_op", busy, 1);
      check("no_err_during_op", err, 0);
      if (was_stall) begin
        check("stall_valid_held", rk_valid, 1);
        check("stall_rk_held", rk, held_rk);
        check("stall_idx_held", rk_idx, held_idx);
      end
      if (rk_valid) begin
        if (beat == abort_beat) begin
          arst_n = 1'b0;
          #1;
          check_reset_values("mid_reset");
          @(negedge mclk);
          arst_n = 1'b1; start = 1'b0; rk_ready = 1'b0;
          return;
        end
        check("rk_idx", rk_idx, beat);
        check("rk", rk, {exp_w[4*beat], exp_w[4*beat+1], exp_w[4*beat+2], exp_w[4*beat+3]});
        cap[beat] = rk;
        if (mode == 0) rdy = 1'b1;
        else if (beat == 3 && stall3 < 5) begin rdy = 1'b0; stall3++; end
        else rdy = 1'($urandom_range(0, 1));
        rk_ready = rdy;
        if (rdy) begin beat++; hs_edge = edge_n; was_stall = 1'b0; end
        else begin stalls++; was_stall = 1'b1; held_rk = rk; held_idx = rk_idx; end
      end else begin
        rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (mode != 0) begin
        start = 1'($urandom_range(0, 1));
        key_len = 2'($urandom);
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      @(negedge mclk);
      edge_n++;
    end
    start = 1'b0;
    checkOutput(beat, nr + 1, hs_edge, budget + stalls);
    rk_ready = 1'b0;
  endtask

  task automatic checkOutput(input int beats, input int exp_beats, input int hs_edge, input int exp_edge);
    check("beat_count", beats, exp_beats);
    check("final_handshake_cycle", hs_edge, exp_edge);
    check("done_pulse", done, 1);
    check("idle_after_done", busy, 0);
    check("valid_after_done", rk_valid, 0);
    @(negedge mclk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_known_128();
    check("k128_idx1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("k128_idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
  endtask

  logic [255:0] key128, key192, key256, rkey;

  initial begin
    build_sbox();
    key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, $urandom, $urandom, $urandom, $urandom};
    key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, $urandom, $urandom};
    key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    arst_n = 1'b0;
    repeat (2) @(negedge mclk);
    check_reset_values("reset");
    arst_n = 1'b1;

    $display("[TB] AES-128 known-answer, ready high");
    applyStimulus(key128, 2'd0, 0, -1);
    check_known_128();

    $display("[TB] AES-192 known-answer");
    applyStimulus(key192, 2'd1, 0, -1);
    check("k192_idx0", cap[0], 128'h000102030405060708090a0b0c0d0e0f);
    check("k192_idx12", cap[12], 128'ha4970a331a78dc09c418c271e3a41d5d);

    $display("[TB] AES-256 known-answer");
    applyStimulus(key256, 2'd2, 0, -1);
    check("k256_idx1", cap[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("k256_idx14", cap[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("[TB] AES-128 with backpressure and ignored starts");
    applyStimulus(key128, 2'd0, 1, -1);
    check_known_128();

    $display("[TB] rejected key lengths");
    @(negedge mclk);
    key_len = 2'd3; start = 1'b1; key_len2 = 2'd1; start2 = 1'b1;
    @(negedge mclk);
    start = 1'b0; start2 = 1'b0;
    check("err_len3", err, 1);
    check("busy_len3", busy, 0);
    check("valid_len3", rk_valid, 0);
    check("err_n192", err2, 1);
    check("busy_n192", busy2, 0);
    check("valid_n192", rk_valid2, 0);
    @(negedge mclk);
    check("err_len3_pulse", err, 0);
    check("err_n192_pulse", err2, 0);
    check("busy_len3_after", busy, 0);
    check("busy_n192_after", busy2, 0);

    $display("[TB] reset mid AES-256 then AES-128");
    applyStimulus(key256, 2'd2, 0, 5);
    check_reset_values("post_reset");
    applyStimulus(key128, 2'd0, 0, -1);
    check_known_128();

    $display("[TB] random keys");
    for (int n = 0; n < 3; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      applyStimulus(rkey, 2'(n), 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
